class_hvec_stream: RTL and testbench
====================================

Name: class_hvec_stream

Overview:
- Parametrised, writable class-hypervector store with a sequential frame streamer.
- Holds NUM_CLASSES class vectors of NUM_FRAMES x FRAME_W bits.
- Streams frames of one class, or of every class in order (sweep), over a valid/ready channel into the similarity/associative-search stage.
- A write port loads or retrains individual frames at run time.

Parameters:
- NUM_CLASSES, 8, number of class hypervectors.
- NUM_FRAMES, 3, frames per class vector.
- FRAME_W, 64, bits per frame (D = NUM_FRAMES*FRAME_W).
- CLASS_W, max(1,clog2(NUM_CLASSES)), derived, not overridable.
- FRAME_IDX_W, max(1,clog2(NUM_FRAMES)), derived, not overridable.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  stream request.
- cmd_ready  out  1  high only in IDLE.
- cmd_sweep  in  1  1 = stream all classes 0..NUM_CLASSES-1; 0 = stream cmd_class only.
- cmd_class  in  CLASS_W  class to stream when cmd_sweep=0.
- cmd_err  out  1  one-cycle pulse: accepted command with cmd_class >= NUM_CLASSES.
- wr_en  in  1  frame write strobe.
- wr_class  in  CLASS_W  write target class.
- wr_frame  in  FRAME_IDX_W  write target frame.
- wr_data  in  FRAME_W  frame value.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts.
- out_data  out  FRAME_W  frame value.
- out_class  out  CLASS_W  class of beat.
- out_frame  out  FRAME_IDX_W  frame index of beat.
- out_last_frame  out  1  beat is frame NUM_FRAMES-1 of its class.
- out_last  out  1  final beat of the command.

Behaviour:
- Reset (async assert, sync release) clears state to IDLE.
  - out_valid, cmd_err, out_last, out_last_frame = 0; out_data, out_class, out_frame = 0; cmd_ready = 1 after release.
  - Storage contents are not reset; the bench loads them via the write port.
- FSM IDLE -> FETCH -> STREAM -> IDLE.
  - IDLE: cmd_ready=1. On cmd_valid:
    - Valid command: latch mode; cur_class = sweep ? 0 : cmd_class; cur_frame = 0; go to FETCH.
    - cmd_sweep=0 and cmd_class >= NUM_CLASSES: cmd_err=1 next cycle, remain IDLE, no beats.
  - FETCH (1 cycle): registered read of mem[cur_class][cur_frame] into out_data; out_valid rises next cycle (first beat 2 cycles after the accept edge).
  - STREAM: out_valid=1. Fields stay stable while out_ready=0.
    - On out_valid && out_ready, advance (frame++, wrapping to 0 with class++ in sweep) and prefetch the next word the same cycle, so back-to-back beats run at 1/cycle.
    - On the accepted beat with out_last=1, go to IDLE; out_valid=0 next cycle; cmd_ready=1 the same cycle.
- Beat counts: single mode = NUM_FRAMES beats; sweep = NUM_CLASSES*NUM_FRAMES beats.
  - out_last_frame = (out_frame==NUM_FRAMES-1).
  - out_last = out_last_frame && (single || out_class==NUM_CLASSES-1).
- Writes are accepted in every state, one per cycle, and update storage on the clock edge.
  - wr_class >= NUM_CLASSES or wr_frame >= NUM_FRAMES: write ignored.
  - Write and fetch to the same address in one cycle: fetch returns the old value (read-before-write).
  - A write to the address of the beat currently presented does not change out_data.
- cmd_valid in non-IDLE states is ignored (cmd_ready=0).
- Reset mid-stream aborts immediately: out_valid=0, no residual beats after release.

Decomposition:
- Shared package hdc_cfg_pkg: NUM_CLASSES, NUM_FRAMES, FRAME_W defaults, clog2-derived widths, FSM state encoding.
- Sub-module class_hvec_bank: NUM_CLASSES*NUM_FRAMES x FRAME_W storage with one write port and one registered read port, read-before-write, inferable as distributed/block RAM.
- The top level holds the FSM, counters and handshake.

Test Plan:
- Load class 2 frames 0..2 with 64'hA..., 64'hB..., 64'hC... (e.g. 64'hAAAA_0000_0000_0002 etc.); single cmd class=2, out_ready=1.
  - Required: 3 beats on consecutive cycles with frames 0,1,2, data A/B/C, out_last on beat 3, cmd_ready back the next cycle.
- Sweep with all 24 frames loaded as {class,frame} patterns, out_ready=1.
  - Required: 24 beats, class 0..7 x frame 0..2 in order, out_last_frame every 3rd beat, out_last only on class 7 frame 2.
- Single cmd class=5 with out_ready toggling 1,0,0,1,...
  - Required: data/class/frame held during stalls, exactly 3 beats, none duplicated or lost.
- cmd_class=7 with NUM_CLASSES=6 build.
  - Required: cmd_err pulse 1 cycle, no out_valid, FSM stays IDLE.
- During a single stream of class 1, write class 1 frame 2 = 64'hFFFF_FFFF_FFFF_FFFF while frame 1 is presented and frame 2 is being fetched.
  - Required: beat 3 shows the old value; a new command shows all-ones.
  - Also: a write with wr_frame=3 is ignored.
- Assert rst_n low after beat 1 of a sweep.
  - Required: out_valid=0 asynchronously; after release, IDLE with cmd_ready=1 and storage intact.

Source files
------------

// File: rtl/class_hvec_stream_pkg.sv
// Shared configuration for the class-hypervector streamer: default geometry,
// index-width helper and FSM state encoding.
package hdc_cfg_pkg;

  localparam int NUM_CLASSES_DEF = 8;
  localparam int NUM_FRAMES_DEF  = 3;
  localparam int FRAME_W_DEF     = 64;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLASS_W_DEF     = idx_w(NUM_CLASSES_DEF);
  localparam int FRAME_IDX_W_DEF = idx_w(NUM_FRAMES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/class_hvec_stream_if.sv
// Command, frame-write and beat-output channels of the class-vector streamer.
// master = producer of commands/writes and consumer of beats; slave = the store.
interface class_hvec_stream_if
  import hdc_cfg_pkg::*;
#(
  parameter int CLASS_W     = CLASS_W_DEF,
  parameter int FRAME_IDX_W = FRAME_IDX_W_DEF,
  parameter int FRAME_W     = FRAME_W_DEF
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_sweep;
  logic [CLASS_W-1:0]     cmd_class;
  logic                   cmd_err;

  logic                   wr_en;
  logic [CLASS_W-1:0]     wr_class;
  logic [FRAME_IDX_W-1:0] wr_frame;
  logic [FRAME_W-1:0]     wr_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [FRAME_W-1:0]     out_data;
  logic [CLASS_W-1:0]     out_class;
  logic [FRAME_IDX_W-1:0] out_frame;
  logic                   out_last_frame;
  logic                   out_last;

  modport master (
    output cmd_valid, cmd_sweep, cmd_class, wr_en, wr_class, wr_frame, wr_data, out_ready,
    input  cmd_ready, cmd_err, out_valid, out_data, out_class, out_frame, out_last_frame, out_last
  );

  modport slave (
    input  cmd_valid, cmd_sweep, cmd_class, wr_en, wr_class, wr_frame, wr_data, out_ready,
    output cmd_ready, cmd_err, out_valid, out_data, out_class, out_frame, out_last_frame, out_last
  );

endinterface

// File: rtl/class_hvec_stream_bank.sv
// Frame storage: one write port, one registered read port. A same-address
// write and read in one cycle returns the old word (read-before-write).
module class_hvec_bank
  import hdc_cfg_pkg::*;
#(
  parameter int DEPTH  = NUM_CLASSES_DEF * NUM_FRAMES_DEF,
  parameter int WIDTH  = FRAME_W_DEF,
  parameter int ADDR_W = idx_w(NUM_CLASSES_DEF * NUM_FRAMES_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on a fetch, so it holds the presented beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/class_hvec_stream.sv
// Writable class-hypervector store that streams the frames of one class, or
// of every class in order, over a valid/ready channel.
module class_hvec_stream
  import hdc_cfg_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int FRAME_W     = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  class_hvec_stream_if.slave bus
);

  localparam int CLASS_W     = idx_w(NUM_CLASSES);
  localparam int FRAME_IDX_W = idx_w(NUM_FRAMES);
  localparam int DEPTH       = NUM_CLASSES * NUM_FRAMES;
  localparam int ADDR_W      = idx_w(DEPTH);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_W-1:0]     LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CLASS_W-1:0] c,
                                                input logic [FRAME_IDX_W-1:0] f);
    return ADDR_W'(c) * ADDR_W'(NUM_FRAMES) + ADDR_W'(f);
  endfunction

  state_e                 state_q, state_d;
  logic                   sweep_q;
  logic [CLASS_W-1:0]     cur_class_q, nxt_class;
  logic [FRAME_IDX_W-1:0] cur_frame_q, nxt_frame;
  logic                   cmd_err_q;
  logic                   cmd_bad, cmd_acc, streaming, fire, is_last_frame, is_last;
  logic                   wr_ok, rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [FRAME_W-1:0]     rd_data;

  // cur_* always names the word sitting in the read register (the presented beat).
  assign cmd_bad       = !bus.cmd_sweep && (32'(bus.cmd_class) >= NUM_CLASSES);
  assign cmd_acc       = (state_q == ST_IDLE) && bus.cmd_valid && !cmd_bad;
  assign streaming     = (state_q == ST_STREAM);
  assign fire          = streaming && bus.out_ready;
  assign is_last_frame = (cur_frame_q == LAST_FRAME);
  assign is_last       = is_last_frame && (!sweep_q || cur_class_q == LAST_CLASS);
  assign nxt_frame     = is_last_frame ? '0 : cur_frame_q + FRAME_IDX_W'(1);
  assign nxt_class     = is_last_frame ? cur_class_q + CLASS_W'(1) : cur_class_q;
  assign wr_ok         = bus.wr_en && (32'(bus.wr_class) < NUM_CLASSES)
                                   && (32'(bus.wr_frame) < NUM_FRAMES);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: one fetch cycle, then stream until the last beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_acc) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_STREAM;
      ST_STREAM: if (fire && is_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake levels and the read strobe; an accepted beat
  // prefetches its successor so back-to-back beats run at one per cycle.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.out_valid = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = addr_of(cur_class_q, cur_frame_q);
    case (state_q)
      ST_IDLE:   bus.cmd_ready = 1'b1;
      ST_FETCH:  rd_en = 1'b1;
      ST_STREAM: begin
        bus.out_valid = 1'b1;
        if (fire && !is_last) begin
          rd_en   = 1'b1;
          rd_addr = addr_of(nxt_class, nxt_frame);
        end
      end
      default: ;
    endcase
  end

  // Command latch, position counters and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q     <= 1'b0;
      cur_class_q <= '0;
      cur_frame_q <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_err_q <= (state_q == ST_IDLE) && bus.cmd_valid && cmd_bad;
      if (cmd_acc) begin
        sweep_q     <= bus.cmd_sweep;
        cur_class_q <= bus.cmd_sweep ? '0 : bus.cmd_class;
        cur_frame_q <= '0;
      end else if (fire && !is_last) begin
        cur_class_q <= nxt_class;
        cur_frame_q <= nxt_frame;
      end
    end
  end

  class_hvec_bank #(
    .DEPTH  (DEPTH),
    .WIDTH  (FRAME_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (addr_of(bus.wr_class, bus.wr_frame)),
    .wdata (bus.wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign bus.cmd_err        = cmd_err_q;
  assign bus.out_data       = rd_data;
  assign bus.out_class      = cur_class_q;
  assign bus.out_frame      = cur_frame_q;
  assign bus.out_last_frame = streaming && is_last_frame;
  assign bus.out_last       = streaming && is_last;

endmodule

// File: tb/tb_class_hvec_stream.sv
// Directed bench for class_hvec_stream: an 8-class build for streaming,
// stall, collision and reset cases, plus a 6-class build for the bad-class error.
module tb_class_hvec_stream;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] exp_mem [8][3];
  logic [63:0] q_data[$];
  int          q_cls[$], q_frm[$], q_lf[$], q_last[$], q_cyc[$];

  class_hvec_stream_if #(.CLASS_W(3), .FRAME_IDX_W(2), .FRAME_W(64)) bus  ();
  class_hvec_stream_if #(.CLASS_W(3), .FRAME_IDX_W(2), .FRAME_W(64)) bus6 ();

  class_hvec_stream #(.NUM_CLASSES(8), .NUM_FRAMES(3), .FRAME_W(64)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave)
  );

  class_hvec_stream #(.NUM_CLASSES(6), .NUM_FRAMES(3), .FRAME_W(64)) u_dut6 (
    .clk (clk), .rst_n (rst_n), .bus (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int c, input int f);
    return 64'h5EED_0000_0000_0000 | (64'(c) << 8) | 64'(f);
  endfunction

  task automatic wr(input int c, input int f, input logic [63:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_class = 3'(c);
    bus.wr_frame = 2'(f);
    bus.wr_data  = d;
    cyc();
    bus.wr_en = 1'b0;
    if (c < 8 && f < 3) exp_mem[c][f] = d;
  endtask

  task automatic issue(input logic sw, input int c);
    bus.cmd_valid = 1'b1;
    bus.cmd_sweep = sw;
    bus.cmd_class = 3'(c);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    cyc();
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_busy", bus.cmd_ready, 0);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready = 1,0,0,1,0,0,...
  task automatic collect(input int mode, input int budget);
    logic [63:0] hd;
    int          hc, hf;
    bit          held, done;
    q_data.delete(); q_cls.delete(); q_frm.delete();
    q_lf.delete(); q_last.delete(); q_cyc.delete();
    held = 0; done = 0; hd = '0; hc = 0; hf = 0;
    for (int k = 0; k < budget && !done; k++) begin
      bus.out_ready = (mode == 0) || (k % 3 == 0);
      if (bus.out_valid) begin
        if (held) begin
          chk("stall_data",  bus.out_data, hd);
          chk("stall_class", bus.out_class, hc);
          chk("stall_frame", bus.out_frame, hf);
        end
        if (bus.out_ready) begin
          q_data.push_back(bus.out_data);
          q_cls.push_back(int'(bus.out_class));
          q_frm.push_back(int'(bus.out_frame));
          q_lf.push_back(int'(bus.out_last_frame));
          q_last.push_back(int'(bus.out_last));
          q_cyc.push_back(k);
          held = 0;
          if (bus.out_last) done = 1;
        end else begin
          held = 1;
          hd = bus.out_data; hc = int'(bus.out_class); hf = int'(bus.out_frame);
        end
      end
      cyc();
    end
    if (!done) chk("stream_timeout", 0, 1);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_beats(input string tag, input bit sweep, input int cls, input bit chk_cyc);
    int n, c, f;
    n = sweep ? 24 : 3;
    chk({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < q_data.size() && i < n; i++) begin
      c = sweep ? i / 3 : cls;
      f = i % 3;
      chk({tag, "_data"},  q_data[i], exp_mem[c][f]);
      chk({tag, "_class"}, q_cls[i], c);
      chk({tag, "_frame"}, q_frm[i], f);
      chk({tag, "_lastfr"}, q_lf[i], (f == 2) ? 1 : 0);
      chk({tag, "_last"},  q_last[i], (i == n - 1) ? 1 : 0);
      if (chk_cyc) chk({tag, "_cyc"}, q_cyc[i], i + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_sweep = 0; bus.cmd_class = '0; bus.out_ready = 0;
    bus.wr_en = 0; bus.wr_class = '0; bus.wr_frame = '0; bus.wr_data = '0;
    bus6.cmd_valid = 0; bus6.cmd_sweep = 0; bus6.cmd_class = '0; bus6.out_ready = 0;
    bus6.wr_en = 0; bus6.wr_class = '0; bus6.wr_frame = '0; bus6.wr_data = '0;
    repeat (3) cyc();

    // reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cmd_err",   bus.cmd_err, 0);
    chk("rst_last",      bus.out_last, 0);
    chk("rst_last_fr",   bus.out_last_frame, 0);
    chk("rst_data",      bus.out_data, 0);
    chk("rst_class",     bus.out_class, 0);
    chk("rst_frame",     bus.out_frame, 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_cmd_ready",  bus.cmd_ready, 1);
    chk("rst_cmd_ready6", bus6.cmd_ready, 1);

    // single stream of class 2, full throughput
    wr(2, 0, 64'hAAAA_0000_0000_0002);
    wr(2, 1, 64'hBBBB_0000_0000_0002);
    wr(2, 2, 64'hCCCC_0000_0000_0002);
    issue(1'b0, 2);
    collect(0, 50);
    check_beats("t1", 1'b0, 2, 1'b1);
    chk("t1_cmd_ready_after", bus.cmd_ready, 1);
    chk("t1_valid_after",     bus.out_valid, 0);

    // sweep over all 24 frames; cmd_class is ignored in sweep mode
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 3; f++)
        wr(c, f, pat(c, f));
    issue(1'b1, 5);
    collect(0, 100);
    check_beats("t2", 1'b1, 0, 1'b1);
    chk("t2_cmd_ready_after", bus.cmd_ready, 1);

    // single stream of class 5 with stalls
    issue(1'b0, 5);
    collect(1, 100);
    check_beats("t3", 1'b0, 5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_no_extra", bus.out_valid, 0);
      cyc();
    end

    // bad class on the 6-class build, including the exact boundary
    for (int t = 0; t < 2; t++) begin
      bus6.cmd_valid = 1'b1;
      bus6.cmd_sweep = 1'b0;
      bus6.cmd_class = (t == 0) ? 3'd7 : 3'd6;
      cyc();
      bus6.cmd_valid = 1'b0;
      chk("t4_err_pulse",  bus6.cmd_err, 1);
      chk("t4_no_valid",   bus6.out_valid, 0);
      chk("t4_stay_idle",  bus6.cmd_ready, 1);
      cyc();
      chk("t4_err_clear",  bus6.cmd_err, 0);
      chk("t4_no_valid2",  bus6.out_valid, 0);
      cyc();
      chk("t4_no_valid3",  bus6.out_valid, 0);
    end
    chk("t4_dut8_no_err", bus.cmd_err, 0);

    // write/fetch collision while streaming class 1
    issue(1'b0, 1);
    bus.out_ready = 1'b1;
    chk("t5_fetch_novalid", bus.out_valid, 0);
    cyc();
    chk("t5_f0_frame", bus.out_frame, 0);
    chk("t5_f0_data",  bus.out_data, pat(1, 0));
    cyc();
    chk("t5_f1_frame", bus.out_frame, 1);
    bus.wr_en = 1'b1; bus.wr_class = 3'd1; bus.wr_frame = 2'd2;
    bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    chk("t5_f2_frame",   bus.out_frame, 2);
    chk("t5_rbw_old",    bus.out_data, pat(1, 2));
    bus.out_ready = 1'b0;
    cyc();
    chk("t5_presented_wr", bus.out_data, pat(1, 2));
    chk("t5_still_valid",  bus.out_valid, 1);
    bus.wr_frame = 2'd3;
    bus.wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.out_ready = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    bus.out_ready = 1'b0;
    chk("t5_done_valid", bus.out_valid, 0);
    chk("t5_done_ready", bus.cmd_ready, 1);
    exp_mem[1][2] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1'b0, 1);
    collect(0, 50);
    check_beats("t5b", 1'b0, 1, 1'b1);
    issue(1'b0, 2);
    collect(0, 50);
    check_beats("t5c", 1'b0, 2, 1'b1);

    // reset in the middle of a sweep
    issue(1'b1, 0);
    bus.out_ready = 1'b1;
    cyc();
    chk("t6_beat1_valid", bus.out_valid, 1);
    cyc();
    chk("t6_beat2_valid", bus.out_valid, 1);
    chk("t6_beat2_frame", bus.out_frame, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_lastfr", bus.out_last_frame, 0);
    cyc();
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk("t6_idle_ready", bus.cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t6_no_residual", bus.out_valid, 0);
      cyc();
    end
    bus.out_ready = 1'b0;
    issue(1'b0, 2);
    collect(0, 50);
    check_beats("t6s", 1'b0, 2, 1'b1);
    issue(1'b0, 7);
    collect(0, 50);
    check_beats("t6t", 1'b0, 7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
